// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing defaults, frame-size helper,
// colour types and the 2x2 Bayer threshold table used by vga_rgb_encoder.
// The table is only consumed when VGA_DITHER_EN is defined.
package vga_timing_pkg;

  // Default horizontal timing, in pixels.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  // Default vertical timing, in lines.
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Raster coordinates are 10-bit unsigned.
  localparam int CNT_W = 10;

  // Total period of one axis (pixels per line or lines per frame).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // One source colour channel.
  typedef logic [3:0] chan_t;

  // Source colour as presented by the pattern/frame source.
  typedef struct packed {
    chan_t r;
    chan_t g;
    chan_t b;
  } rgb_t;

  // Ordered-dither thresholds indexed by {y[0], x[0]}:
  // (0,0)=2, (0,1)=10, (1,0)=14, (1,1)=6.
  localparam logic [3:0][3:0] BAYER_T = {4'd6, 4'd14, 4'd10, 4'd2};

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters advanced by the pixel strike, the
// registered request coordinate/visibility, and raw active-low sync decodes
// of the current coordinate. The sync decodes are retimed by the top so they
// line up with the encoded colour pins.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pix_en_i,
  output logic [CNT_W-1:0] req_x_o,
  output logic [CNT_W-1:0] req_y_o,
  output logic             req_active_o,
  output logic             hsync_raw_o,
  output logic             vsync_raw_o
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // All decode points are constants; the counters are only ever compared.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             active_q, active_d;

  // Next raster position: step one pixel per strike, wrap line then frame.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_i) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + CNT_W'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
    active_d = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
  end

  // Raster position and visibility register; reset restarts at (0,0).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      active_q <= 1'b1;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      active_q <= active_d;
    end
  end

  assign req_x_o      = h_cnt_q;
  assign req_y_o      = v_cnt_q;
  assign req_active_o = active_q;

  // Sync pulses are active low inside their windows.
  assign hsync_raw_o = !((h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END));
  assign vsync_raw_o = !((v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END));

endmodule

// File: rtl/vga_rgb_encoder.sv
// vga_rgb_encoder: 640x480@60 raster for 1-bit-per-channel VGA pins.
// Requests source pixels by coordinate and quantises each 4-bit channel to
// one bit. Build macro VGA_DITHER_EN selects 2x2 ordered dithering; without
// it each pin is simply the channel MSB. Colour and sync pins share a single
// output register so they stay aligned, one pixel period behind the request.
module vga_rgb_encoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] req_x,
  output logic [9:0] req_y,
  output logic       req_active,
  input  logic [3:0] in_RED,
  input  logic [3:0] in_GREEN,
  input  logic [3:0] in_BLUE,
  output logic       RED,
  output logic       GREEN,
  output logic       BLUE,
  output logic       HSYNC,
  output logic       VSYNC
);

  logic hsync_raw;
  logic vsync_raw;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_i        (clk),
    .rst_i        (rst),
    .pix_en_i     (pix_en),
    .req_x_o      (req_x),
    .req_y_o      (req_y),
    .req_active_o (req_active),
    .hsync_raw_o  (hsync_raw),
    .vsync_raw_o  (vsync_raw)
  );

  rgb_t src;
  assign src = {in_RED, in_GREEN, in_BLUE};

`ifdef VGA_DITHER_EN
  // Pixel lights when the channel exceeds the Bayer threshold for its cell.
  function automatic logic quantise(input chan_t v, input logic x0,
                                    input logic y0);
    return v > BAYER_T[{y0, x0}];
  endfunction

  logic [2:0] rgb_quant;
  assign rgb_quant = {quantise(src.r, req_x[0], req_y[0]),
                      quantise(src.g, req_x[0], req_y[0]),
                      quantise(src.b, req_x[0], req_y[0])};
`else
  // Flat threshold of 7: the pin is the channel MSB.
  function automatic logic quantise(input chan_t v);
    return v[3];
  endfunction

  logic [2:0] rgb_quant;
  assign rgb_quant = {quantise(src.r), quantise(src.g), quantise(src.b)};
`endif

  logic [2:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  // Output stage loads on the strike; blanking forces black.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (pix_en) begin
      rgb_d   = req_active ? rgb_quant : 3'b000;
      hsync_d = hsync_raw;
      vsync_d = vsync_raw;
    end
  end

  // Pin register; reset drives black with both syncs idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= 3'b000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign RED   = rgb_q[2];
  assign GREEN = rgb_q[1];
  assign BLUE  = rgb_q[0];
  assign HSYNC = hsync_q;
  assign VSYNC = vsync_q;

endmodule
